// File: rtl/gray_pkg.sv
// ---------------------------------------------------------------------------
// gray_pkg
// Shared definitions for the Gray-code decoder block:
//   - DEFAULT_N      : default width of the Gray input / binary output
//   - lock_state_t   : lock tracker FSM state encodings
//   - step_class_t   : classification of one decoded sample relative to the
//                      previously decoded value (GOOD / HOLD / BAD)
// ---------------------------------------------------------------------------
package gray_pkg;

  localparam int DEFAULT_N = 8;

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } lock_state_t;

  typedef enum logic [1:0] {
    STEP_GOOD = 2'd0,  // new == prev + 1 (mod 2^N)
    STEP_HOLD = 2'd1,  // new == prev
    STEP_BAD  = 2'd2   // anything else
  } step_class_t;

endpackage : gray_pkg

// File: rtl/gray2bin.sv
// ---------------------------------------------------------------------------
// gray2bin
// Purely combinational Gray-to-binary converter.
//   b[N-1] = g[N-1]
//   b[i]   = b[i+1] ^ g[i]
// Each output bit is written as the XOR-reduction of all Gray bits from its
// own position upwards, which is the same function without a chain of
// references between output bits.
// Ports:
//   i_gray  in  N  Gray-coded value
//   o_bin   out N  binary equivalent
// ---------------------------------------------------------------------------
module gray2bin
  import gray_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic [N-1:0] i_gray,
  output logic [N-1:0] o_bin
);

  assign o_bin[N-1] = i_gray[N-1];

  genvar gi;
  generate
    for (gi = 0; gi < N - 1; gi++) begin : g_bit
      assign o_bin[gi] = ^i_gray[N-1:gi];
    end
  endgenerate

endmodule : gray2bin

// File: rtl/gray_decoder.sv
// ---------------------------------------------------------------------------
// gray_decoder
// Two-stage Gray-to-binary decoder with a sequence tracker.
//   Stage 1 registers gray_in (when clk_en) and a valid flag.
//   gray2bin converts the stage-1 value combinationally.
//   Stage 2 registers the binary value into bin_out and pulses bin_valid.
//   In the same stage-2 cycle each decoded sample is classified against the
//   previous decoded value and drives a two-state lock tracker; an illegal
//   step while locked pulses step_err and bumps a saturating error counter.
// Ports:
//   clk        in   1      clock, all state on rising edge
//   rst        in   1      synchronous active-high reset
//   clk_en     in   1      sample strobe for gray_in
//   gray_in    in   N      Gray-coded count
//   err_clr    in   1      synchronous clear of err_count (wins over step_err)
//   bin_out    out  N      registered binary value
//   bin_valid  out  1      one-cycle pulse when bin_out updates
//   locked     out  1      tracking a legal +1 Gray sequence
//   step_err   out  1      one-cycle pulse: illegal step while locked
//   err_count  out  ERR_W  saturating count of step_err pulses
// ---------------------------------------------------------------------------
module gray_decoder
  import gray_pkg::*;
#(
  parameter int N        = DEFAULT_N,
  parameter int LOCK_CNT = 2,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic [N-1:0]     gray_in,
  input  logic             err_clr,
  output logic [N-1:0]     bin_out,
  output logic             bin_valid,
  output logic             locked,
  output logic             step_err,
  output logic [ERR_W-1:0] err_count
);

  localparam int               CNT_W   = $clog2(LOCK_CNT + 1);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(LOCK_CNT - 1);

  // Stage 1
  logic [N-1:0]     r_s1_gray;
  logic             r_s1_valid;
  // Stage 2 / tracker state
  logic [N-1:0]     r_bin;
  logic             r_bin_valid;
  logic             r_primed;
  logic [CNT_W-1:0] r_good_cnt;
  lock_state_t      r_state;
  logic             r_step_err;
  logic [ERR_W-1:0] r_err_count;

  // Combinational
  logic [N-1:0]     w_s1_bin;
  logic [N-1:0]     w_prev_bin;
  logic [N-1:0]     w_prev_inc;
  step_class_t      w_step;
  lock_state_t      w_state_next;
  logic [CNT_W-1:0] w_good_cnt_next;
  logic             w_primed_next;
  logic             w_step_err_next;

  // -------------------------------------------------------------------------
  // Stage 1: capture gray_in on the strobe, valid flag follows clk_en
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_gray  <= '0;
      r_s1_valid <= 1'b0;
    end else begin
      r_s1_valid <= clk_en;
      if (clk_en) begin
        r_s1_gray <= gray_in;
      end
    end
  end

  gray2bin #(
    .N (N)
  ) u_gray2bin (
    .i_gray (r_s1_gray),
    .o_bin  (w_s1_bin)
  );

  // -------------------------------------------------------------------------
  // Stage 2: bin_out register. It updates on exactly the same condition as
  // the "last decoded value", so it doubles as prev_bin for classification.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bin       <= '0;
      r_bin_valid <= 1'b0;
    end else begin
      r_bin_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_bin <= w_s1_bin;
      end
    end
  end

  assign w_prev_bin = r_bin;
  assign w_prev_inc = w_prev_bin + N'(1);  // wraps 2^N-1 -> 0 naturally

  always_comb begin
    w_step = STEP_BAD;
    if (w_s1_bin == w_prev_inc) begin
      w_step = STEP_GOOD;
    end else if (w_s1_bin == w_prev_bin) begin
      w_step = STEP_HOLD;
    end
  end

  // -------------------------------------------------------------------------
  // Lock tracker FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_UNLOCKED;
      r_good_cnt <= '0;
      r_primed   <= 1'b0;
      r_step_err <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_good_cnt <= w_good_cnt_next;
      r_primed   <= w_primed_next;
      r_step_err <= w_step_err_next;
    end
  end

  // -------------------------------------------------------------------------
  // Lock tracker FSM: next state. Decisions are taken only for a sample that
  // is being written into bin_out this cycle, so locked/step_err change on
  // the same edge that raises bin_valid for the deciding sample.
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next    = r_state;
    w_good_cnt_next = r_good_cnt;
    w_primed_next   = r_primed;
    w_step_err_next = 1'b0;

    if (r_s1_valid) begin
      if (!r_primed) begin
        // First sample after reset has nothing to compare against.
        w_primed_next = 1'b1;
      end else begin
        case (r_state)
          ST_UNLOCKED: begin
            case (w_step)
              STEP_GOOD: begin
                if (r_good_cnt == CNT_TOP) begin
                  w_state_next    = ST_LOCKED;
                  w_good_cnt_next = '0;
                end else begin
                  w_good_cnt_next = r_good_cnt + CNT_W'(1);
                end
              end
              STEP_HOLD: w_good_cnt_next = r_good_cnt;
              default:   w_good_cnt_next = '0;
            endcase
          end
          ST_LOCKED: begin
            if (w_step == STEP_BAD) begin
              w_step_err_next = 1'b1;
              w_state_next    = ST_UNLOCKED;
              w_good_cnt_next = '0;
            end
          end
          default: begin
            w_state_next    = ST_UNLOCKED;
            w_good_cnt_next = '0;
          end
        endcase
      end
    end
  end

  // -------------------------------------------------------------------------
  // Saturating error counter; clear has priority over a coincident error.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_count <= '0;
    end else if (err_clr) begin
      r_err_count <= '0;
    end else if (w_step_err_next && (r_err_count != ERR_MAX)) begin
      r_err_count <= r_err_count + ERR_W'(1);
    end
  end

  assign bin_out   = r_bin;
  assign bin_valid = r_bin_valid;
  assign locked    = (r_state == ST_LOCKED);
  assign step_err  = r_step_err;
  assign err_count = r_err_count;

endmodule : gray_decoder

// File: doc/gray_decoder.md
GRAY_DECODER -- requirements
Module: gray_decoder

Interface
REQ-001 Parameter N, default 8, width of Gray input and binary output.
REQ-002 Parameter LOCK_CNT, default 2, consecutive good steps required to lock.
REQ-003 Parameter ERR_W, default 8, error counter width.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 clk_en  input  1  sample strobe; gray_in captured only when 1.
REQ-007 gray_in  input  N  Gray-coded count from the Gray counter.
REQ-008 err_clr  input  1  synchronous clear of err_count.
REQ-009 bin_out  output  N  registered binary equivalent of the sampled gray_in.
REQ-010 bin_valid  output  1  one-cycle pulse: bin_out updated.
REQ-011 locked  output  1  1 while the input is tracking a legal +1 Gray sequence.
REQ-012 step_err  output  1  one-cycle pulse: illegal transition detected while locked.
REQ-013 err_count  output  ERR_W  saturating count of step_err pulses.

Function
REQ-014 Stage 1 SHALL register gray_in and a valid flag (= clk_en) every cycle; gray data held when clk_en=0.
REQ-015 Conversion SHALL be b[N-1]=g[N-1], b[i]=b[i+1] XOR g[i] for i=N-2..0.
REQ-016 Stage 2 SHALL register the converted value into bin_out when stage-1 valid=1; bin_valid SHALL pulse for that cycle only.
REQ-017 Latency SHALL be exactly 2 clk cycles from the clk_en=1 sampling edge to bin_valid=1; back-to-back clk_en SHALL give back-to-back bin_valid.
REQ-018 Block SHALL keep prev_bin, the last decoded value, updated on every bin_valid.
REQ-019 Step classes per decoded sample: GOOD if new == (prev_bin+1) mod 2^N; HOLD if new == prev_bin; BAD otherwise.
REQ-020 Wrap-around 2^N-1 -> 0 (Gray 100..0 -> 000..0) SHALL be GOOD.
REQ-021 FSM states: UNLOCKED, LOCKED; locked=1 iff state=LOCKED.
REQ-022 UNLOCKED: first sample after reset only loads prev_bin; GOOD increments good_cnt; HOLD leaves it; BAD resets it to 0; good_cnt reaching LOCK_CNT -> LOCKED with good_cnt cleared.
REQ-023 LOCKED: GOOD and HOLD stay LOCKED without error; BAD SHALL pulse step_err in the same cycle as bin_valid and go to UNLOCKED.
REQ-024 step_err SHALL never assert in UNLOCKED.
REQ-025 err_count SHALL increment on step_err and saturate at 2^ERR_W-1.
REQ-026 err_clr SHALL zero err_count next cycle; err_clr together with step_err yields 0 (clear wins); step_err still pulses.
REQ-027 locked changes SHALL coincide with the bin_valid cycle of the deciding sample.

Reset
REQ-028 rst=1 SHALL on the next edge set bin_out=0, bin_valid=0, locked=0, step_err=0, err_count=0, prev_bin=0, good_cnt=0, both pipeline valid flags=0, state=UNLOCKED.
REQ-029 rst mid-operation SHALL flush the pipeline: no bin_valid in the 2 cycles after rst deasserts unless clk_en sampled after deassertion.
REQ-030 rst SHALL override clk_en and err_clr.

Structure
REQ-031 Shared package gray_pkg SHALL hold default N, FSM state encodings, and the GOOD/HOLD/BAD step-class encodings.
REQ-032 Combinational Gray-to-binary conversion SHALL be a sub-module gray2bin (parameter N), instantiated between stage 1 and stage 2.

Verification
REQ-033 N=8, rst, then clk_en=1 continuously with a legal Gray count from 0 -> bin_out 0,1,2,... with bin_valid every cycle, 2-cycle latency, locked=1 on the 3rd decoded sample.
REQ-034 Locked, drive Gray 0x80 (bin 255) then 0x00 -> bin_out 255 then 0, no step_err, locked stays 1.
REQ-035 Locked at bin 5 (Gray 0x07), inject Gray 0x0C (bin 8) -> step_err pulse, err_count=1, locked=0; two further GOOD steps relock.
REQ-036 ERR_W=2, force 5 BAD events with relocks between -> err_count saturates at 3; err_clr asserted with 6th step_err -> err_count=0.
REQ-037 clk_en toggling 1,0,0,1 with same gray_in -> two bin_valid pulses, second is HOLD, no error, lock state unchanged.
REQ-038 rst asserted one cycle after a clk_en sample -> no bin_valid from that sample, all outputs 0, locked=0.
